// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state encoding and default detector pattern
//   seq_gen_state_t : IDLE / SEND / GAP, shared with the detector-side bench
//   DET_PATTERN     : default 4-bit pattern recognised by the Moore detector
package seq_gen_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP} seq_gen_state_t;
  localparam logic [3:0] DET_PATTERN = 4'b1011;
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-load, shift-left register with MSB serial output
//   clock, reset (async active-low), load (priority over shift), shift,
//   din [WIDTH-1:0] parallel word, msb serial output
module piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);
  logic [WIDTH-1:0] sr;
  always_ff @(posedge clock or negedge reset)
    if (!reset) sr <= '0;
    else if (load) sr <= din;
    else if (shift) sr <= {sr[WIDTH-2:0], 1'b0};
  assign msb = sr[WIDTH-1];
endmodule

// File: rtl/seq_gen_moore_fsm.sv
// seq_gen_moore_fsm: serial pattern transmitter with repeat count and idle gaps
//   clock, reset (async active-low)
//   data_in [WIDTH-1:0], repeat_in [CNT_W-1:0], start_valid -> start_ready
//   sequence_out serial MSB-first stream, busy in SEND/GAP,
//   frame_done one-cycle pulse in the first IDLE cycle after the final bit
module seq_gen_moore_fsm #(
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] repeat_in,
  input  logic             start_valid,
  output logic             start_ready,
  output logic             sequence_out,
  output logic             busy,
  output logic             frame_done
);
  import seq_gen_pkg::*;
  localparam int BW = $clog2(WIDTH);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  seq_gen_state_t state, state_n;
  logic [WIDTH-1:0] hold, hold_n, load_data;
  logic [CNT_W-1:0] rep_cnt, rep_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic done_q, done_n, load, shift, msb;
  piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
    .clock(clock),
    .reset(reset),
    .load(load),
    .shift(shift),
    .din(load_data),
    .msb(msb)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      hold    <= '0;
      rep_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      hold    <= hold_n;
      rep_cnt <= rep_n;
      bit_cnt <= bit_n;
      gap_cnt <= gap_n;
      done_q  <= done_n;
    end
  always_comb begin
    state_n   = state;
    hold_n    = hold;
    rep_n     = rep_cnt;
    bit_n     = bit_cnt;
    gap_n     = gap_cnt;
    done_n    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    load_data = hold;
    case (state)
      IDLE: if (start_valid) begin
        state_n   = SEND;
        load      = 1'b1;
        load_data = data_in;
        hold_n    = data_in;
        rep_n     = repeat_in;
        bit_n     = '0;
      end
      SEND: begin
        shift = 1'b1;
        bit_n = bit_cnt + 1'b1;
        if (bit_cnt == BIT_LAST) begin
          bit_n = '0;
          if (rep_cnt == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else if (GAP_CYCLES == 0) begin
            load  = 1'b1;
            rep_n = rep_cnt - 1'b1;
          end else begin
            state_n = GAP;
            gap_n   = '0;
          end
        end
      end
      GAP: if (gap_cnt == GAP_LAST) begin
        state_n = SEND;
        load    = 1'b1;
        rep_n   = rep_cnt - 1'b1;
        gap_n   = '0;
      end else gap_n = gap_cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  assign start_ready  = state == IDLE;
  assign busy         = state != IDLE;
  assign sequence_out = (state == SEND) & msb;
  assign frame_done   = done_q;
endmodule

// File: tb/tb_seq_gen_moore_fsm.sv
// tb_seq_gen_moore_fsm: self-checking bench for seq_gen_moore_fsm (GAP=2 and GAP=0 instances)
module tb_seq_gen_moore_fsm;
  import seq_gen_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] d0, d1, r0, r1;
  logic v0, v1, rdy0, rdy1, so0, so1, by0, by1, fd0, fd1;
  int n_cmp = 0, n_err = 0;

  seq_gen_moore_fsm #(.WIDTH(4), .CNT_W(4), .GAP_CYCLES(2)) dut (
    .clock(clk), .reset(rst_n), .data_in(d0), .repeat_in(r0), .start_valid(v0),
    .start_ready(rdy0), .sequence_out(so0), .busy(by0), .frame_done(fd0)
  );
  seq_gen_moore_fsm #(.WIDTH(4), .CNT_W(4), .GAP_CYCLES(0)) dut_nogap (
    .clock(clk), .reset(rst_n), .data_in(d1), .repeat_in(r1), .start_valid(v1),
    .start_ready(rdy1), .sequence_out(so1), .busy(by1), .frame_done(fd1)
  );

  typedef struct {
    bit         sel;
    logic [3:0] d;
    logic [3:0] r;
    int         busy;
    int         ones;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sample(input bit sel, output logic so, output logic by, output logic fd, output logic rdy);
    so  = sel ? so1 : so0;
    by  = sel ? by1 : by0;
    fd  = sel ? fd1 : fd0;
    rdy = sel ? rdy1 : rdy0;
  endtask

  task automatic kick(input bit sel, input logic [3:0] d, input logic [3:0] r);
    if (sel) begin d1 = d; r1 = r; v1 = 1'b1; end
    else begin d0 = d; r0 = r; v0 = 1'b1; end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    d0 = 4'($urandom); d1 = 4'($urandom); r0 = 4'($urandom); r1 = 4'($urandom);
  endtask

  // Builds the expected stream from the frame/gap rules and checks it cycle by cycle,
  // starting in the first cycle after acceptance; returns positioned in the frame_done cycle.
  task automatic expect_frames(input bit sel, input logic [3:0] d, input logic [3:0] r, input string tag);
    bit q[$];
    int g = sel ? 0 : 2;
    logic so, by, fd, rdy;
    for (int f = 0; f <= int'(r); f++) begin
      for (int b = 3; b >= 0; b--) q.push_back(d[b]);
      if (f < int'(r)) repeat (g) q.push_back(1'b0);
    end
    foreach (q[i]) begin
      sample(sel, so, by, fd, rdy);
      check({tag, "_stream"}, {so, by, fd, rdy}, {q[i], 3'b100});
      @(negedge clk);
    end
    sample(sel, so, by, fd, rdy);
    check({tag, "_done"}, {so, by, fd, rdy}, 4'b0011);
  endtask

  initial begin
    int cyc, ones, hits;
    logic so, by, fd, rdy;
    logic [3:0] win;
    bit exp_bits[4];
    tbl[0] = '{1'b0, 4'b1011, 4'd0, 4, 3};
    tbl[1] = '{1'b0, 4'b1011, 4'd2, 16, 9};
    tbl[2] = '{1'b0, 4'b0000, 4'd15, 94, 0};
    tbl[3] = '{1'b0, 4'b1111, 4'd15, 94, 64};
    tbl[4] = '{1'b1, 4'b1011, 4'd1, 8, 6};
    tbl[5] = '{1'b1, 4'b0110, 4'd3, 16, 8};
    tbl[6] = '{1'b0, 4'b1000, 4'd3, 22, 4};
    tbl[7] = '{1'b1, 4'b1111, 4'd15, 64, 64};
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; r0 = '0; r1 = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {rdy0, so0, by0, fd0}, 4'b1000);
    check("reset_state_nogap", {rdy1, so1, by1, fd1}, 4'b1000);
    rst_n = 1'b1;
    kick(0, 4'b1011, 4'd0);
    expect_frames(0, 4'b1011, 4'd0, "single");
    @(negedge clk);
    check("done_one_cycle", fd0, 0);

    foreach (tbl[k]) begin
      kick(tbl[k].sel, tbl[k].d, tbl[k].r);
      ones = 0;
      for (cyc = 0; cyc < 200; cyc++) begin
        sample(tbl[k].sel, so, by, fd, rdy);
        if (!by) break;
        ones += int'(so);
        @(negedge clk);
      end
      check($sformatf("tbl%0d_busy", k), cyc, tbl[k].busy);
      check($sformatf("tbl%0d_ones", k), ones, tbl[k].ones);
      check($sformatf("tbl%0d_done", k), {fd, rdy}, 2'b11);
      @(negedge clk);
    end

    kick(0, 4'b1011, 4'd0);
    exp_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    foreach (exp_bits[i]) begin
      check("busy_reject_stream", {so0, by0, fd0}, {exp_bits[i], 2'b10});
      d0 = 4'b0110; r0 = 4'd5; v0 = 1'b1;
      @(negedge clk);
    end
    check("busy_reject_done", {fd0, rdy0}, 2'b11);
    d0 = 4'b1101; r0 = 4'd0;
    @(negedge clk);
    v0 = 1'b0;
    expect_frames(0, 4'b1101, 4'd0, "accept_on_done");
    @(negedge clk);

    kick(0, 4'b1011, 4'd3);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("reset_midframe", {so0, by0, fd0, rdy0}, 4'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      hits += int'(fd0 | by0 | so0);
    end
    check("no_done_after_reset", hits, 0);

    kick(1, DET_PATTERN, 4'd1);
    win = '0; hits = 0;
    for (cyc = 0; cyc < 40 && by1; cyc++) begin
      win = {win[2:0], so1};
      if (win == DET_PATTERN) hits++;
      @(negedge clk);
    end
    check("loopback_detects", hits, 2);
    check("loopback_done", fd1, 1);
    @(negedge clk);

    repeat (24) begin
      bit sel;
      logic [3:0] d, r;
      sel = 1'($urandom_range(0, 1));
      d = 4'($urandom);
      r = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      kick(sel, d, r);
      expect_frames(sel, d, r, "rand");
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/seq_gen_moore_fsm.md
# seq_gen_moore_fsm

Serial pattern transmitter that drives the `sequence_in` line of the team's Moore sequence detectors. It accepts a parallel pattern word and a repeat count through a valid/ready handshake. It then shifts the word out MSB-first, one bit per clock, with a programmable run of idle zeros between repetitions. All outputs are registered Moore outputs, so the block can feed a detector directly in loopback benches and on-chip self-test.

## Interface
- `WIDTH`, default 4: pattern length in bits (≥2).
- `CNT_W`, default 4: width of the repeat count.
- `GAP_CYCLES`, default 2: zero-valued cycles inserted between consecutive repetitions. 0 means back-to-back frames.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `data_in`  in  WIDTH: pattern to send, MSB transmitted first.
- `repeat_in`  in  CNT_W: extra repetitions. Total frames = `repeat_in`+1.
- `start_valid`  in  1: request to start a transmission.
- `start_ready`  out  1: block is IDLE and can accept a request.
- `sequence_out`  out  1: serial bit stream.
- `busy`  out  1: high in SEND and GAP.
- `frame_done`  out  1: one-cycle pulse after the last bit of the final frame.

## Operation
- States: IDLE, SEND, GAP (shared enum).
- IDLE:
  - `start_ready`=1, `sequence_out`=0.
  - On `start_valid && start_ready`: latch `data_in` into the shift register and the hold register, latch `repeat_in` into the repeat counter, clear the bit counter, go to SEND.
- SEND:
  - `sequence_out` = shift register MSB.
  - Shift left each cycle; the bit counter increments.
  - On bit WIDTH-1:
    - If the repeat counter is 0 → IDLE and set `frame_done`.
    - Else if `GAP_CYCLES`=0 → reload the shift register from the hold register, decrement the repeat counter, stay in SEND.
    - Else → GAP.
- GAP:
  - `sequence_out`=0.
  - The gap counter counts `GAP_CYCLES` cycles. On the last one: reload the shift register, decrement the repeat counter, go to SEND.
- `data_in` and `repeat_in` are ignored outside the accepting edge. Changes during SEND/GAP have no effect.
- `start_valid` while busy is ignored and not queued.
- Counter widths:
  - Bit counter: $clog2(WIDTH).
  - Gap counter: $clog2(GAP_CYCLES+1), minimum 1.
  - Repeat counter: CNT_W, decrements only, never wraps.
- Reset (asynchronous, any state): state=IDLE, shift/hold/counters=0, `sequence_out`=0, `busy`=0, `frame_done`=0, `start_ready`=1. A frame interrupted by reset is abandoned and `frame_done` does not pulse.

## Timing
- Handshake accepted at edge E. The MSB appears on `sequence_out` from E+1, and each bit is held exactly one cycle.
- Frame duration is WIDTH cycles. Total busy time = (R+1)·WIDTH + R·GAP_CYCLES cycles, where R=`repeat_in`.
- `frame_done` is high for exactly one cycle: the first IDLE cycle after the last bit. `start_ready` is already 1 in that cycle, so a request accepted then starts the next frame with zero dead cycles beyond it.
- `start_ready` is decoded from the registered state and has no combinational path from `start_valid`.
- Release of reset is asynchronous at the input and sampled synchronously. The first handshake can be accepted on the first edge after deassertion.

## Structure
- Package `seq_gen_pkg`: the state enum `seq_gen_state_t` (IDLE/SEND/GAP) and a localparam for the default detector pattern 4'b1011. The detector-side bench reuses both.
- One sub-module: `piso_shift_reg` (parallel load, shift-left, MSB out, WIDTH-parameterised). The FSM, counters and handshake stay in the top module.

## Test plan
- Single frame: WIDTH=4, `data_in`=4'b1011, `repeat_in`=0. `sequence_out` = 1,0,1,1 on cycles E+1..E+4. `frame_done` pulses at E+5. `busy` is high E+1..E+4.
- Repeats with gap: `repeat_in`=2, GAP_CYCLES=2. Stream is 1011 00 1011 00 1011, with `busy` high for 16 cycles and one `frame_done`.
- Loopback: feed `sequence_out` into the Moore 1011 detector with `repeat_in`=1, GAP_CYCLES=0. The detector output asserts once per completed 1011, twice total.
- Busy rejection: assert `start_valid` with 4'b0110 mid-frame. It is ignored, and the original pattern completes unchanged. A request held high during the `frame_done` cycle is accepted, and the new MSB appears the next cycle.
- Reset mid-operation: pull `reset` low at bit 2 of a frame. `sequence_out`, `busy` and `frame_done` go to 0 immediately. `start_ready`=1. No `frame_done` follows.
- Edge values: `data_in`=all-zeros and all-ones, and `repeat_in`=max (15). The exact bit count is 16·WIDTH + 15·GAP_CYCLES, and the repeat counter never wraps.
